// File: rtl/shift_cmd_seq.sv
// shift_cmd_seq: expands one shift/load command into reg_control control-code cycles and reports the result
module shift_cmd_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_sin_bits,
  input  logic [WIDTH-1:0] reg_out,
  output logic [2:0]       control,
  output logic             s_in,
  output logic [WIDTH-1:0] d_in,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data
);
  localparam int K_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_steps;
  logic [WIDTH-1:0] r_data, r_sin;
  logic [K_W-1:0]   r_k;
  logic             w_accept, w_shift;
  assign w_accept = cmd_valid && (r_state == IDLE);
  assign w_shift  = cmd_op[2] | cmd_op[1];
  // state register; reset abandons any command in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state and control decode, all from registered state so cmd_* never reach control combinationally
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    control   = 3'b001;
    d_in      = reg_out;
    s_in      = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept) w_next = (w_shift && cmd_count == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        control = r_op;
        d_in    = (r_op == 3'b001) ? r_data : reg_out;
        s_in    = (r_op == 3'b101) ? r_sin[r_k] : 1'b0;
        if (r_steps == CNT_W'(1)) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // command latch, step/serial-bit counters and one-cycle result pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_op      <= '0;
      r_steps   <= '0;
      r_data    <= '0;
      r_sin     <= '0;
      r_k       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= (r_state == DONE);
      if (r_state == DONE) res_data <= reg_out;
      if (w_accept) begin
        r_op    <= cmd_op;
        r_data  <= cmd_data;
        r_sin   <= cmd_sin_bits;
        r_steps <= w_shift ? cmd_count : CNT_W'(1);
        r_k     <= '0;
      end else if (r_state == ISSUE) begin
        r_steps <= r_steps - CNT_W'(1);
        r_k     <= (r_k == K_W'(WIDTH - 1)) ? '0 : r_k + K_W'(1);
      end
    end
endmodule

// File: tb/tb_shift_cmd_seq.sv
// tb_shift_cmd_seq: drives shift_cmd_seq against a behavioural reg_control and a per-command result model
module tb_shift_cmd_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_count = '0;
  logic [7:0] cmd_data = '0;
  logic [7:0] cmd_sin_bits = '0;
  logic [7:0] reg_q = '0;
  logic [2:0] control;
  logic       s_in;
  logic [7:0] d_in;
  logic       busy;
  logic       res_valid;
  logic [7:0] res_data;
  int         errors = 0;
  int         checks = 0;
  int         accepts = 0;
  logic [7:0] exp_reg = '0;

  shift_cmd_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_sin_bits(cmd_sin_bits),
    .reg_out(reg_q), .control(control), .s_in(s_in), .d_in(d_in), .busy(busy),
    .res_valid(res_valid), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // behavioural reg_control: the register the sequencer steers
  always @(posedge clk)
    case (control)
      3'd0: reg_q <= 8'h00;
      3'd1: reg_q <= d_in;
      3'd2: reg_q <= {1'b0, reg_q[7:1]};
      3'd3: reg_q <= {reg_q[6:0], 1'b0};
      3'd4: reg_q <= {reg_q[7], reg_q[7:1]};
      3'd5: reg_q <= {s_in, reg_q[7:1]};
      3'd6: reg_q <= {reg_q[0], reg_q[7:1]};
      default: reg_q <= {reg_q[6:0], reg_q[7]};
    endcase

  always @(posedge clk)
    if (reset && cmd_valid && cmd_ready) accepts <= accepts + 1;

  // final register value of a whole command, computed directly from the operation's meaning
  function automatic logic [7:0] ref_cmd(input logic [7:0] v, input logic [2:0] op, input int n,
                                         input logic [7:0] d, input logic [7:0] s);
    int r;
    logic [7:0] w;
    r = n % 8;
    w = v;
    case (op)
      3'd0: w = 8'h00;
      3'd1: w = d;
      3'd2: w = v >> n;
      3'd3: w = v << n;
      3'd4: w = 8'($signed(v) >>> n);
      3'd5: for (int i = 0; i < n; i++) w = {s[i % 8], w[7:1]};
      3'd6: w = 8'((v >> r) | (v << (8 - r)));
      default: w = 8'((v << r) | (v >> (8 - r)));
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // presents one command at a negedge with the sequencer idle, follows it to its result pulse
  task automatic issue(input logic [2:0] op, input int cnt, input logic [7:0] d, input logic [7:0] s,
                       input bit hold);
    int n, c, nz, si, a0;
    logic [15:0] sq, esq;
    logic [7:0] e;
    n = (op < 3'd2) ? 1 : cnt;
    e = ref_cmd(exp_reg, op, cnt, d, s);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_count = 4'(cnt);
    cmd_data = d;
    cmd_sin_bits = s;
    chk("ready_before", 32'(cmd_ready), 32'd1);
    a0 = accepts;
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    chk("accept_once", 32'(accepts - a0), 32'd1);
    c = 0; nz = 0; si = 0; sq = '0;
    while (!res_valid && c < 40) begin
      if (control != 3'b001) nz++;
      if (control == 3'b101 && si < 16) begin sq[si] = s_in; si++; end
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    chk("latency", 32'(c), 32'(n + 1));
    chk("ctl_cycles", 32'(nz), (op == 3'd1) ? 32'd0 : 32'(n));
    chk("res_data", 32'(res_data), 32'(e));
    chk("ready_at_res", 32'(cmd_ready), 32'd1);
    chk("no_reaccept", 32'(accepts - a0), 32'd1);
    if (op == 3'd5) begin
      esq = '0;
      for (int i = 0; i < n; i++) esq[i] = s[i % 8];
      chk("s_in_seq", 32'(sq), 32'(esq));
    end
    exp_reg = e;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rv;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_control", 32'(control), 32'd1);
    chk("rst_s_in", 32'(s_in), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    issue(3'd1, 0, 8'hAA, 8'h00, 1'b0);
    issue(3'd6, 3, 8'h00, 8'h00, 1'b0);
    issue(3'd1, 0, 8'hAA, 8'h00, 1'b0);
    issue(3'd4, 2, 8'h00, 8'h00, 1'b0);
    issue(3'd1, 0, 8'h81, 8'h00, 1'b0);
    issue(3'd3, 1, 8'h00, 8'h00, 1'b0);
    issue(3'd2, 8, 8'h00, 8'h00, 1'b0);
    issue(3'd0, 0, 8'h00, 8'h00, 1'b0);
    issue(3'd5, 4, 8'h00, 8'b0000_1011, 1'b0);
    chk("sin_shr_value", 32'(res_data), 32'hB0);
    issue(3'd1, 0, 8'h3C, 8'h00, 1'b0);
    issue(3'd7, 0, 8'h00, 8'h00, 1'b0);
    issue(3'd1, 0, 8'h5A, 8'h00, 1'b1);
    issue(3'd6, 5, 8'h00, 8'h00, 1'b1);
    issue(3'd5, 11, 8'h00, 8'b1001_0110, 1'b1);
    issue(3'd3, 2, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 30; i++)
      issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), (i % 3) == 0);
    cmd_valid = 1'b0;
    issue(3'd1, 0, 8'hFF, 8'h00, 1'b0);
    cmd_valid = 1'b1;
    cmd_op = 3'd7;
    cmd_count = 4'd10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_control", 32'(control), 32'd1);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_res_data", 32'(res_data), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rv = 1'b0;
    repeat (6) begin
      @(negedge clk);
      rv = rv | res_valid;
    end
    chk("abort_no_pulse", 32'(rv), 32'd0);
    chk("abort_hold", 32'(reg_q), 32'hFF);
    chk("abort_idle", 32'(busy), 32'd0);
    exp_reg = 8'hFF;
    issue(3'd2, 3, 8'h00, 8'h00, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
